frame_stream_reader: RTL
========================

// Module: frame_stream_reader
// PURPOSE
// - Reads a WIDTH x HEIGHT frame from the dual-clock frame buffer's read port and emits it as an
//   Avalon-ST video packet (sop/eop/valid/ready) to the video scaler sink on the VGA clock domain.
// - Replaces the ad-hoc row/col counter: honours back-pressure and the RAM's 1-cycle read latency
//   with a 2-entry skid FIFO. Sustains 1 pixel/clk when src_ready is held high.
// PARAMETERS
// - WIDTH   320  pixels per line
// - HEIGHT  240  lines per frame
// - ADDR_W  17   frame buffer address width (WIDTH*HEIGHT-1 must fit)
// - DATA_W  12   pixel width (RGB444)
// PORTS
// - clk          in   1       VGA pixel clock (25 MHz); single clock domain
// - reset_n      in   1       asynchronous, active-low reset
// - enable       in   1       level: stream frames continuously while high
// - rd_addr      out  ADDR_W  frame buffer read address
// - rd_data      in   DATA_W  frame buffer q, valid 1 clk after rd_addr
// - src_data     out  DATA_W  pixel to scaler sink
// - src_valid    out  1       src_data/sop/eop valid
// - src_ready    in   1       sink accepts when valid&ready at rising edge
// - src_sop      out  1       high with pixel (0,0)
// - src_eop      out  1       high with pixel (WIDTH-1,HEIGHT-1)
// - frame_done   out  1       1-clk pulse on the cycle the eop beat is accepted
// - busy         out  1       high in STREAM/DRAIN
// BEHAVIOUR
// - Reset (async assert, sync deassert at reg level): all outputs 0, FIFO empty, addr/row/col 0, IDLE.
// - FSM: IDLE -> STREAM when enable=1 sampled. STREAM -> DRAIN after last address (index
//   WIDTH*HEIGHT-1) issued. DRAIN -> STREAM if enable=1 when eop beat accepted, else -> IDLE.
//   Frames are atomic: enable dropping mid-frame does not truncate; frame finishes, then IDLE.
// - Read issue: in STREAM, rd_en=1 iff (fifo_count + inflight - pop) < 2, pop = valid&ready.
//   rd_addr increments by 1 per issued read; wraps to 0 after WIDTH*HEIGHT-1. col/row counters
//   travel with the read (1-stage tag pipe) to derive sop/eop; no multiplier.
// - Latency: enable sampled at edge k -> rd_addr=0 issued in cycle k+1 -> data pushed at edge k+2
//   -> src_valid=1 from edge k+2 (FIFO head drives outputs combinationally from registers).
// - FIFO: 2 entries {data,sop,eop}; push on returning read, pop on valid&ready; simultaneous
//   push+pop keeps count. Never overflows by credit rule; overflow is an assertion failure.
// - src_valid stays high with data/sop/eop stable until accepted (Avalon-ST rule, no retraction).
// - rd_addr holds its last value when no read is issued.
// - frame_done pulses exactly once per frame, same cycle as eop acceptance.
// - Reset mid-frame: immediate abort, FIFO flushed; next frame restarts at address 0 with sop.
// CONFIGURATION
// - FSR_TEST_PATTERN_EN defined: adds input pattern_sel (1 bit). When 1, latched at frame start
//   (sop issue) for the whole frame, src_data = 8 vertical colour bars (bar = col*8/WIDTH; colours
//   white,yellow,cyan,green,magenta,red,blue,black as RGB444 F/0 nibbles), rd_data ignored;
//   addressing/timing identical. Not defined: no pattern_sel port, src_data always rd_data.
// TESTING
// - Reset then enable=1, src_ready=1, RAM[i]=i[11:0] -> valid at enable+2 clk, 76800 beats,
//   data=0..76799 mod 4096, sop on beat 0 only, eop on beat 76799, no bubbles after first beat.
// - src_ready random 50% -> same beat sequence, no loss/duplication, outputs stable while stalled.
// - enable=1 two frames back-to-back, ready=1 -> second sop immediately after first eop, 2 pulses.
// - enable dropped at beat 1000 -> frame completes to eop, frame_done pulses, busy=0, valid=0 after.
// - reset_n pulsed low at beat 5000 -> outputs 0 asynchronously; re-enable restarts at address 0.
// - FSR_TEST_PATTERN_EN, pattern_sel=1 -> beat 0 = 12'hFFF, beat 40 = 12'hFF0, beat 319 = 12'h000.

Source files
------------

// File: rtl/frame_stream_reader.sv
// frame_stream_reader
//   Walks a WIDTH x HEIGHT frame through the frame buffer read port and emits
//   it as an Avalon-ST video packet to the scaler sink. Back-pressure and the
//   one-cycle read latency of the RAM are absorbed by a 2-entry skid FIFO.
//   Each read is issued only when a FIFO slot is guaranteed for its data, so
//   the stream sustains one pixel per clock while src_ready stays high.
//
// Optional feature (macro FSR_TEST_PATTERN_EN):
//   Adds input pattern_sel. When it is high as a frame starts, that whole
//   frame is replaced by 8 vertical colour bars and rd_data is ignored.
//   Addressing and timing do not change.
//
// Ports
//   clk         VGA pixel clock (single clock domain)
//   reset_n     asynchronous active-low reset
//   enable      keep streaming whole frames while high
//   pattern_sel colour-bar select (only with FSR_TEST_PATTERN_EN)
//   rd_addr     frame buffer read address
//   rd_data     frame buffer data, valid one clock after rd_addr
//   src_data    pixel to the sink
//   src_valid   src_data/src_sop/src_eop are valid
//   src_ready   sink accepts on valid & ready at the rising edge
//   src_sop     first pixel of the frame
//   src_eop     last pixel of the frame
//   frame_done  one-cycle pulse while the eop beat is being accepted
//   busy        a frame is being read or drained
module frame_stream_reader #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
`ifdef FSR_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic              frame_done,
  output logic              busy
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  // Tag pipe: travels alongside the read that is currently in flight.
  logic              inflight;
  logic              tag_sop;
  logic              tag_eop;

  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_sop;
  logic [1:0]        fifo_eop;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;

  logic              pop;
  logic              push;
  logic [2:0]        credit;
  logic              rd_en;
  logic              issue_first;
  logic              issue_last;
  logic [DATA_W-1:0] push_data;

  assign pop         = src_valid & src_ready;
  assign push        = inflight;
  // Slots already committed after this cycle's pop; a new read needs a free one.
  assign credit      = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en       = (state == STREAM) && (credit < 3'd2);
  assign issue_first = (col == '0) && (row == '0);
  assign issue_last  = (col == COL_LAST) && (row == ROW_LAST);

  assign src_valid   = (fifo_count != 2'd0);
  assign src_data    = fifo_data[rd_ptr];
  assign src_sop     = fifo_sop[rd_ptr];
  assign src_eop     = fifo_eop[rd_ptr];
  assign frame_done  = pop & src_eop;

`ifdef FSR_TEST_PATTERN_EN
  logic       pattern_frame;
  logic       tag_pattern;
  logic [2:0] tag_bar;

  // Bar index col*8/WIDTH, found by counting the bar boundaries the column
  // has passed. This avoids a divider.
  function automatic logic [2:0] bar_of(input logic [COL_W-1:0] c);
    logic [2:0] b;
    int         c_int;
    b     = 3'd0;
    c_int = int'(c);
    for (int t = 1; t < 8; t++) begin
      if (c_int * 8 >= t * WIDTH) b = b + 3'd1;
    end
    return b;
  endfunction

  function automatic logic [11:0] bar_colour(input logic [2:0] b);
    logic [11:0] rgb;
    case (b)
      3'd0:    rgb = 12'hFFF;
      3'd1:    rgb = 12'hFF0;
      3'd2:    rgb = 12'h0FF;
      3'd3:    rgb = 12'h0F0;
      3'd4:    rgb = 12'hF0F;
      3'd5:    rgb = 12'hF00;
      3'd6:    rgb = 12'h00F;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

  // The select is latched when the sop read issues. The sop read takes the
  // live value so the frame is uniform from its very first pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_frame <= 1'b0;
      tag_pattern   <= 1'b0;
      tag_bar       <= 3'd0;
    end else begin
      if (rd_en && issue_first) pattern_frame <= pattern_sel;
      tag_pattern <= (rd_en && issue_first) ? pattern_sel : pattern_frame;
      tag_bar     <= bar_of(col);
    end
  end

  assign push_data = tag_pattern ? DATA_W'(bar_colour(tag_bar)) : rd_data;
`else
  assign push_data = rd_data;
`endif

  // Frame sequencing. A frame always runs to its eop. The eop acceptance
  // decides whether the next frame starts straight away or the block idles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (rd_en && issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (frame_done) begin
            if (enable) begin
              state <= STREAM;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read address plus column/row position of the next read to issue. All
  // three wrap together after the last pixel, so every frame begins at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      col     <= '0;
      row     <= '0;
    end else if (rd_en) begin
      if (issue_last) begin
        rd_addr <= '0;
        col     <= '0;
        row     <= '0;
      end else begin
        rd_addr <= rd_addr + ADDR_W'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // One-stage tag pipe that matches the RAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      tag_sop  <= 1'b0;
      tag_eop  <= 1'b0;
    end else begin
      inflight <= rd_en;
      tag_sop  <= rd_en & issue_first;
      tag_eop  <= rd_en & issue_last;
    end
  end

  // Two-entry skid FIFO. The head entry drives the source outputs directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_sop     <= 2'b00;
      fifo_eop     <= 2'b00;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_sop[wr_ptr]  <= tag_sop;
        fifo_eop[wr_ptr]  <= tag_eop;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The read credit rule must never let a returning read find the FIFO full.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (fifo_count == 2'd2)));
`endif

endmodule
